// File: rtl/mpu_core_arbiter_pkg.sv
// +--------------------------------------------------------------------------+
// | mpu_core_arbiter_pkg : shared MPU widths, error codes and arbiter states |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package mpu_core_arbiter_pkg;

  localparam int CORE_ID_WIDTH       = 2;
  localparam int ADDR_WIDTH          = 32;
  localparam int DATA_WIDTH          = 32;
  localparam int DEFAULT_ARB_TIMEOUT = 1024;

  typedef logic [ADDR_WIDTH-1:0] addr_bits_t;
  typedef logic [DATA_WIDTH-1:0] data_bits_t;

  typedef enum logic [1:0] {
    MPU_NO_ERROR      = 2'd0,
    MPU_ACCESS_DENIED = 2'd1,
    MPU_OUT_OF_MEMORY = 2'd2,
    MPU_INVALID_FREE  = 2'd3
  } mpu_error_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/mpu_core_arbiter_rr_arbiter.sv
// +--------------------------------------------------------------------------+
// | mpu_core_arbiter_rr_arbiter : combinational round-robin grant picker     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module mpu_core_arbiter_rr_arbiter
  import mpu_core_arbiter_pkg::*;
#(
  parameter int NUM_CORES = 4
) (
  input  logic [NUM_CORES-1:0]     req,
  input  logic [CORE_ID_WIDTH-1:0] last_grant,
  output logic [NUM_CORES-1:0]     gnt,
  output logic [CORE_ID_WIDTH-1:0] gnt_idx,
  output logic                     gnt_valid
);

  int idx;

  // Search starts just after the previous winner so it becomes lowest priority.
  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = 0;
    for (int i = 0; i < NUM_CORES; i++) begin
      idx = (int'(last_grant) + 1 + i) % NUM_CORES;
      if (!gnt_valid && req[idx]) begin
        gnt[idx]  = 1'b1;
        gnt_idx   = CORE_ID_WIDTH'(idx);
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mpu_core_arbiter.sv
// +--------------------------------------------------------------------------+
// | mpu_core_arbiter : round-robin front end that serialises core requests   |
// | onto the single MPU port, with watchdog and echoed-id checking           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module mpu_core_arbiter
  import mpu_core_arbiter_pkg::*;
#(
  parameter int NUM_CORES      = 4,
  parameter int TIMEOUT_CYCLES = DEFAULT_ARB_TIMEOUT
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_CORES-1:0]             req_valid,
  output logic [NUM_CORES-1:0]             req_ready,
  input  logic [NUM_CORES-1:0]             req_cfg,
  input  logic [NUM_CORES-1:0]             req_we,
  input  logic [NUM_CORES-1:0]             req_free_reserve,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_CORES*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_CORES-1:0]             resp_valid,
  output logic [DATA_WIDTH-1:0]            resp_rdata,
  output mpu_error_t                       resp_err,
  output logic                             mpu_cs,
  output logic                             mpu_cfg,
  output logic                             mpu_we,
  output logic                             mpu_free_reserve,
  output logic [CORE_ID_WIDTH-1:0]         mpu_core_id,
  output logic [ADDR_WIDTH-1:0]            mpu_addr,
  output logic [DATA_WIDTH-1:0]            mpu_wdata,
  input  logic                             mpu_rdy,
  input  logic                             mpu_bsy,
  input  logic [DATA_WIDTH-1:0]            mpu_rdata,
  input  mpu_error_t                       mpu_err,
  input  logic [CORE_ID_WIDTH-1:0]         mpu_source_core_id,
  output logic                             timeout_err,
  output logic                             proto_err
);

  localparam int WD_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  // Counter is 0 in the first WAIT cycle and the response lands one cycle after
  // expiry, so resp_valid appears exactly TIMEOUT_CYCLES after mpu_cs.
  localparam logic [WD_WIDTH-1:0] WD_LIMIT = WD_WIDTH'(TIMEOUT_CYCLES - 2);

  arb_state_t                 state_q, state_d;
  logic [CORE_ID_WIDTH-1:0]   last_grant_q, last_grant_d;
  logic [CORE_ID_WIDTH-1:0]   grant_idx_q, grant_idx_d;
  logic                       cfg_q, cfg_d, we_q, we_d, fr_q, fr_d;
  addr_bits_t                 addr_q, addr_d;
  data_bits_t                 wdata_q, wdata_d;
  logic [WD_WIDTH-1:0]        wd_q, wd_d;
  logic [NUM_CORES-1:0]       resp_valid_q, resp_valid_d;
  data_bits_t                 resp_rdata_q, resp_rdata_d;
  mpu_error_t                 resp_err_q, resp_err_d;
  logic                       timeout_err_q, timeout_err_d;
  logic                       proto_err_q, proto_err_d;

  logic [NUM_CORES-1:0]       gnt;
  logic [CORE_ID_WIDTH-1:0]   gnt_idx;
  logic                       gnt_valid;
  logic [NUM_CORES-1:0]       owner_onehot;

  mpu_core_arbiter_rr_arbiter #(
    .NUM_CORES (NUM_CORES)
  ) u_rr_arbiter (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx),
    .gnt_valid  (gnt_valid)
  );

  assign owner_onehot = NUM_CORES'(1) << grant_idx_q;

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant_idx_d   = grant_idx_q;
    cfg_d         = cfg_q;
    we_d          = we_q;
    fr_d          = fr_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wd_d          = wd_q;
    resp_valid_d  = '0;
    resp_rdata_d  = resp_rdata_q;
    resp_err_d    = resp_err_q;
    timeout_err_d = timeout_err_q;
    proto_err_d   = proto_err_q;
    req_ready     = '0;

    unique case (state_q)
      ARB_IDLE: begin
        // Ready is gated by rst_n so no accept is advertised during reset.
        if (rst_n && !mpu_bsy && gnt_valid) begin
          req_ready    = gnt;
          last_grant_d = gnt_idx;
          grant_idx_d  = gnt_idx;
          cfg_d        = req_cfg[gnt_idx];
          we_d         = req_we[gnt_idx];
          fr_d         = req_free_reserve[gnt_idx];
          addr_d       = req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d      = req_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
          state_d      = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        wd_d    = '0;
        state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        wd_d = wd_q + 1'b1;
        if (mpu_rdy) begin
          resp_rdata_d = mpu_rdata;
          resp_err_d   = mpu_err;
          resp_valid_d = owner_onehot;
          if (mpu_source_core_id != grant_idx_q) begin
            proto_err_d = 1'b1;
          end
          state_d = ARB_RESP;
        end else if (wd_q == WD_LIMIT) begin
          resp_rdata_d  = '0;
          resp_err_d    = MPU_ACCESS_DENIED;
          resp_valid_d  = owner_onehot;
          timeout_err_d = 1'b1;
          state_d       = ARB_RESP;
        end
      end
      ARB_RESP: begin
        if (!mpu_bsy) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ARB_IDLE;
      last_grant_q  <= CORE_ID_WIDTH'(NUM_CORES - 1);
      grant_idx_q   <= '0;
      cfg_q         <= 1'b0;
      we_q          <= 1'b0;
      fr_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wd_q          <= '0;
      resp_valid_q  <= '0;
      resp_rdata_q  <= '0;
      resp_err_q    <= MPU_NO_ERROR;
      timeout_err_q <= 1'b0;
      proto_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      grant_idx_q   <= grant_idx_d;
      cfg_q         <= cfg_d;
      we_q          <= we_d;
      fr_q          <= fr_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wd_q          <= wd_d;
      resp_valid_q  <= resp_valid_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_err_q    <= resp_err_d;
      timeout_err_q <= timeout_err_d;
      proto_err_q   <= proto_err_d;
    end
  end

  assign mpu_cs           = (state_q == ARB_ISSUE);
  assign mpu_cfg          = cfg_q;
  assign mpu_we           = we_q;
  assign mpu_free_reserve = fr_q;
  assign mpu_core_id      = grant_idx_q;
  assign mpu_addr         = addr_q;
  assign mpu_wdata        = wdata_q;
  assign resp_valid       = resp_valid_q;
  assign resp_rdata       = resp_rdata_q;
  assign resp_err         = resp_err_q;
  assign timeout_err      = timeout_err_q;
  assign proto_err        = proto_err_q;

endmodule

`default_nettype wire

// File: tb/tb_mpu_core_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_mpu_core_arbiter : random + directed bench with a transaction-level   |
// | reference model of the core arbiter. Revision: 1.0                       |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_mpu_core_arbiter;
  import mpu_core_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int TO = 16;
  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int IW = CORE_ID_WIDTH;
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic [N-1:0]        req_valid, req_ready, req_cfg, req_we, req_free_reserve;
  logic [N*AW-1:0]     req_addr;
  logic [N*DW-1:0]     req_wdata;
  logic [N-1:0]        resp_valid;
  logic [DW-1:0]       resp_rdata;
  mpu_error_t          resp_err;
  logic                mpu_cs, mpu_cfg, mpu_we, mpu_free_reserve;
  logic [IW-1:0]       mpu_core_id;
  logic [AW-1:0]       mpu_addr;
  logic [DW-1:0]       mpu_wdata;
  logic                mpu_rdy, mpu_bsy;
  logic [DW-1:0]       mpu_rdata;
  mpu_error_t          mpu_err;
  logic [IW-1:0]       mpu_source_core_id;
  logic                timeout_err, proto_err;

  mpu_core_arbiter #(.NUM_CORES(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_cfg(req_cfg), .req_we(req_we),
    .req_free_reserve(req_free_reserve), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mpu_cs(mpu_cs), .mpu_cfg(mpu_cfg), .mpu_we(mpu_we), .mpu_free_reserve(mpu_free_reserve),
    .mpu_core_id(mpu_core_id), .mpu_addr(mpu_addr), .mpu_wdata(mpu_wdata),
    .mpu_rdy(mpu_rdy), .mpu_bsy(mpu_bsy), .mpu_rdata(mpu_rdata), .mpu_err(mpu_err),
    .mpu_source_core_id(mpu_source_core_id),
    .timeout_err(timeout_err), .proto_err(proto_err)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Stimulus state
  logic [N-1:0] acc_seen = '0;
  logic         cs_seen = 1'b0;
  logic [IW-1:0] cs_id_seen = '0;
  logic [N-1:0] auto_mask;
  int           prob, lat_force, src_override, cnt;
  bit           bsy_force, never_rdy, rand_faults, pend;
  logic [IW-1:0] pend_src;
  logic [DW-1:0] rdq[$];
  mpu_error_t    errq[$];

  // Observation logs
  int            acc_cyc_q[$], acc_core_q[$], cs_cyc_q[$], resp_cyc_q[$];
  logic [N-1:0]  resp_vec_q[$];
  logic [DW-1:0] resp_dat_q[$];
  mpu_error_t    resp_err_q[$];

  // Reference model: one outstanding transaction described by its cycle stamps
  bit            m_valid = 1'b0, m_active, m_to, m_pe;
  int            m_owner, m_cs_c, m_resp_c, m_last, m_g, m_c;
  logic [DW-1:0] m_rdata;
  mpu_error_t    m_err;
  logic          m_cfg, m_we, m_fr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [N-1:0]  m_exp_ready, m_exp_rv;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(negedge clk);
    m_g = -1;
    if (m_valid) begin
      if (rst_n && !m_active && !mpu_bsy)
        for (int k = 1; k <= N; k++) begin
          m_c = (m_last + k) % N;
          if (m_g < 0 && req_valid[m_c]) m_g = m_c;
        end
      m_exp_ready = (m_g >= 0) ? (ONE << m_g) : '0;
      m_exp_rv    = (m_active && cyc == m_resp_c) ? (ONE << m_owner) : '0;
      chk("req_ready", req_ready, m_exp_ready);
      chk("mpu_cs", mpu_cs, m_active && cyc == m_cs_c);
      chk("resp_valid", resp_valid, m_exp_rv);
      chk("resp_rdata", resp_rdata, m_rdata);
      chk("resp_err", resp_err, m_err);
      chk("timeout_err", timeout_err, m_to);
      chk("proto_err", proto_err, m_pe);
      if (m_active) begin
        chk("mpu_core_id", mpu_core_id, m_owner);
        chk("mpu_addr", mpu_addr, m_addr);
        chk("mpu_wdata", mpu_wdata, m_wdata);
        chk("mpu_ctl", {mpu_cfg, mpu_we, mpu_free_reserve}, {m_cfg, m_we, m_fr});
      end
    end
    for (int i = 0; i < N; i++)
      if (req_valid[i] && req_ready[i]) begin acc_cyc_q.push_back(cyc); acc_core_q.push_back(i); end
    if (mpu_cs) cs_cyc_q.push_back(cyc);
    if (|resp_valid) begin
      resp_cyc_q.push_back(cyc); resp_vec_q.push_back(resp_valid);
      resp_dat_q.push_back(resp_rdata); resp_err_q.push_back(resp_err);
    end
    acc_seen = req_valid & req_ready;
    cs_seen  = mpu_cs;
    if (mpu_cs) cs_id_seen = mpu_core_id;

    if (!rst_n) begin
      m_valid = 1'b1; m_active = 1'b0; m_last = N - 1;
      m_rdata = '0; m_err = MPU_NO_ERROR; m_to = 1'b0; m_pe = 1'b0;
    end else if (m_valid) begin
      if (m_g >= 0) begin
        m_active = 1'b1; m_owner = m_g; m_last = m_g;
        m_cs_c = cyc + 1; m_resp_c = -1;
        m_cfg = req_cfg[m_g]; m_we = req_we[m_g]; m_fr = req_free_reserve[m_g];
        m_addr = req_addr[m_g*AW +: AW]; m_wdata = req_wdata[m_g*DW +: DW];
      end else if (m_active) begin
        if (m_resp_c < 0 && cyc > m_cs_c) begin
          if (mpu_rdy) begin
            m_resp_c = cyc + 1; m_rdata = mpu_rdata; m_err = mpu_err;
            if (int'(mpu_source_core_id) != m_owner) m_pe = 1'b1;
          end else if (cyc - m_cs_c == TO - 1) begin
            m_resp_c = cyc + 1; m_rdata = '0; m_err = MPU_ACCESS_DENIED; m_to = 1'b1;
          end
        end else if (m_resp_c >= 0 && cyc >= m_resp_c && !mpu_bsy) begin
          m_active = 1'b0;
        end
      end
    end
    cyc++;
  end

  task automatic raise(input int c);
    req_valid[c]              = 1'b1;
    req_cfg[c]                = 1'($urandom_range(0, 1));
    req_we[c]                 = 1'($urandom_range(0, 1));
    req_free_reserve[c]       = 1'($urandom_range(0, 1));
    req_addr[c*AW +: AW]      = $urandom;
    req_wdata[c*DW +: DW]     = $urandom;
  endtask

  // One clock of stimulus: core request generators plus a behavioural MPU.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc_seen[i]) req_valid[i] = 1'b0;
      if (!req_valid[i] && auto_mask[i] && $urandom_range(0, 99) < prob) raise(i);
    end
    mpu_rdy            = 1'b0;
    mpu_rdata          = $urandom;
    mpu_err            = mpu_error_t'(2'($urandom_range(0, 3)));
    mpu_source_core_id = IW'($urandom_range(0, N - 1));
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (cs_seen && !never_rdy && !(rand_faults && $urandom_range(0, 15) == 0)) begin
        pend = 1'b1;
        cnt  = (lat_force >= 0) ? lat_force : $urandom_range(0, 8);
        if (src_override >= 0) pend_src = IW'(src_override);
        else if (rand_faults && $urandom_range(0, 15) == 0) pend_src = cs_id_seen + 1'b1;
        else pend_src = cs_id_seen;
      end
      if (pend) begin
        if (cnt == 0) begin
          mpu_rdy = 1'b1; pend = 1'b0;
          mpu_source_core_id = pend_src;
          if (rdq.size() > 0) mpu_rdata = rdq.pop_front();
          if (errq.size() > 0) mpu_err = errq.pop_front();
        end else begin
          cnt--;
        end
      end
    end
    mpu_bsy = bsy_force | pend | mpu_rdy;
  endtask

  task automatic clear_logs();
    acc_cyc_q.delete(); acc_core_q.delete(); cs_cyc_q.delete(); resp_cyc_q.delete();
    resp_vec_q.delete(); resp_dat_q.delete(); resp_err_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; auto_mask = '0; prob = 0;
    never_rdy = 1'b0; rand_faults = 1'b0; bsy_force = 1'b0;
    lat_force = -1; src_override = -1;
    rdq.delete(); errq.delete();
    step(); step();
    rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic wait_resp(input int n, input string name);
    int budget;
    budget = 200;
    while (resp_cyc_q.size() < n && budget > 0) begin step(); budget--; end
    chk({name, "_resp_count"}, resp_cyc_q.size(), n);
  endtask

  int fall_cyc;

  initial begin
    rst_n = 1'b0; req_valid = '0; req_cfg = '0; req_we = '0; req_free_reserve = '0;
    req_addr = '0; req_wdata = '0; mpu_rdy = 1'b0; mpu_bsy = 1'b0; mpu_rdata = '0;
    mpu_err = MPU_NO_ERROR; mpu_source_core_id = '0; pend = 1'b0; cnt = 0; pend_src = '0;
    auto_mask = '0; prob = 0; lat_force = -1; src_override = -1;
    bsy_force = 1'b0; never_rdy = 1'b0; rand_faults = 1'b0;

    // 1: MPU busy after reset blocks acceptance
    bsy_force = 1'b1;
    step(); step();
    rst_n = 1'b1;
    clear_logs();
    chk("t1_reset_resp_valid", resp_valid, 0);
    chk("t1_reset_resp_err", resp_err, MPU_NO_ERROR);
    raise(0);
    repeat (20) step();
    chk("t1_no_accept_while_bsy", acc_cyc_q.size(), 0);
    bsy_force = 1'b0;
    step();
    fall_cyc = cyc;
    step();
    chk("t1_first_accept_cycle", (acc_cyc_q.size() > 0) ? acc_cyc_q[0] : -1, fall_cyc);
    chk("t1_first_accept_core", (acc_core_q.size() > 0) ? acc_core_q[0] : -1, 0);
    wait_resp(1, "t1");

    // 2: simultaneous requests from cores 0 and 1
    do_reset();
    rdq.push_back(32'h100); rdq.push_back(32'h200);
    errq.push_back(MPU_NO_ERROR); errq.push_back(MPU_NO_ERROR);
    raise(0); raise(1);
    wait_resp(2, "t2");
    chk("t2_first_vec", resp_vec_q.size() > 0 ? resp_vec_q[0] : '0, 4'b0001);
    chk("t2_first_data", resp_dat_q.size() > 0 ? resp_dat_q[0] : '0, 32'h100);
    chk("t2_second_vec", resp_vec_q.size() > 1 ? resp_vec_q[1] : '0, 4'b0010);
    chk("t2_second_data", resp_dat_q.size() > 1 ? resp_dat_q[1] : '0, 32'h200);

    // 3: all cores continuously valid
    do_reset();
    auto_mask = '1; prob = 100;
    for (int b = 0; b < 400 && acc_core_q.size() < 8; b++) step();
    chk("t3_accept_count", acc_core_q.size() >= 8, 1);
    for (int i = 0; i < 8; i++)
      chk("t3_grant_order", acc_core_q.size() > i ? acc_core_q[i] : -1, i % 4);

    // 4: denied access on core 2 with correct echoed id
    do_reset();
    errq.push_back(MPU_ACCESS_DENIED);
    raise(2);
    req_cfg[2] = 1'b0;
    wait_resp(1, "t4");
    chk("t4_vec", resp_vec_q.size() > 0 ? resp_vec_q[0] : '0, 4'b0100);
    chk("t4_err", resp_err_q.size() > 0 ? resp_err_q[0] : MPU_NO_ERROR, MPU_ACCESS_DENIED);
    chk("t4_proto_err", proto_err, 0);

    // 5: MPU never answers
    do_reset();
    never_rdy = 1'b1;
    raise(1);
    wait_resp(1, "t5");
    chk("t5_latency", (resp_cyc_q.size() > 0 && cs_cyc_q.size() > 0) ?
        resp_cyc_q[0] - cs_cyc_q[0] : -1, 16);
    chk("t5_data", resp_dat_q.size() > 0 ? resp_dat_q[0] : 32'hdead, 0);
    chk("t5_err", resp_err_q.size() > 0 ? resp_err_q[0] : MPU_NO_ERROR, MPU_ACCESS_DENIED);
    repeat (5) step();
    chk("t5_timeout_sticky", timeout_err, 1);
    never_rdy = 1'b0;

    // 6: wrong echoed id, then reset in the middle of a wait
    do_reset();
    src_override = 3;
    raise(1);
    wait_resp(1, "t6");
    chk("t6_vec", resp_vec_q.size() > 0 ? resp_vec_q[0] : '0, 4'b0010);
    repeat (3) step();
    chk("t6_proto_err", proto_err, 1);
    src_override = -1;
    lat_force = 10;
    clear_logs();
    raise(0);
    for (int b = 0; b < 50 && cs_cyc_q.size() == 0; b++) step();
    repeat (3) step();
    rst_n = 1'b0;
    step();
    chk("t6_rst_resp_valid", resp_valid, 0);
    chk("t6_rst_flags", {timeout_err, proto_err, mpu_cs}, 0);
    chk("t6_rst_rdata", resp_rdata, 0);
    rst_n = 1'b1;
    repeat (20) step();
    chk("t6_no_resp_after_reset", resp_cyc_q.size(), 0);

    // Random traffic with occasional hung MPU and corrupted echo ids
    do_reset();
    auto_mask = '1; prob = 30; rand_faults = 1'b1;
    repeat (3000) step();
    chk("rand_progress", resp_cyc_q.size() > 100, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation exceeded its time bound");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/mpu_core_arbiter.md
Name: mpu_core_arbiter

Overview:
- Sits directly upstream of the MPU top.
- Accepts configure (malloc/dealloc) and access-check requests from NUM_CORES independent core ports and arbitrates them round-robin.
- Drives the MPU's single-request cs/bsy/rdy interface, then routes the MPU result back to the originating core as a one-cycle response pulse.
- Adds a per-transaction watchdog and a core-id consistency check.

Parameters:
- NUM_CORES, 4, number of requesting cores; must be <= 2**CORE_ID_WIDTH.
- TIMEOUT_CYCLES, 1024, maximum cycles waiting for mpu_rdy before the transaction is aborted.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset: synchronous, active-low
- req_valid  in  NUM_CORES  per-core request valid
- req_ready  out  NUM_CORES  per-core accept (combinational)
- req_cfg  in  NUM_CORES  per-core cfg bit (1 = configure)
- req_we  in  NUM_CORES  per-core write enable
- req_free_reserve  in  NUM_CORES  per-core free_reserve
- req_addr  in  NUM_CORES x ADDR_WIDTH  per-core addr_bits_t
- req_wdata  in  NUM_CORES x DATA_WIDTH  per-core data_bits_t
- resp_valid  out  NUM_CORES  one-cycle response pulse to the owning core
- resp_rdata  out  DATA_WIDTH  response data, shared by all cores
- resp_err  out  mpu_error_t  response status, shared by all cores
- mpu_cs, mpu_cfg, mpu_we, mpu_free_reserve  out  1  MPU request controls
- mpu_core_id  out  CORE_ID_WIDTH  granted core index
- mpu_addr  out  ADDR_WIDTH  latched addr
- mpu_wdata  out  DATA_WIDTH  latched wdata
- mpu_rdy, mpu_bsy  in  1  MPU status
- mpu_rdata  in  DATA_WIDTH  MPU read data
- mpu_err  in  mpu_error_t  MPU status code
- mpu_source_core_id  in  CORE_ID_WIDTH  core id echoed by the MPU
- timeout_err  out  1  sticky; watchdog fired
- proto_err  out  1  sticky; echoed id mismatched the grant

Behaviour:

Reset values:
- All outputs 0; resp_err = MPU_NO_ERROR.
- State ARB_IDLE; rr pointer set so core 0 has highest priority.
- An in-flight transaction is dropped with no response.

ARB_IDLE:
- When mpu_bsy == 0 and any req_valid is high, pick grant g by round-robin starting at last_grant+1 (wrapping modulo NUM_CORES).
- req_ready[g] = 1 that same cycle; at most one ready bit is ever high.
- On that edge: latch the request fields, set last_grant = g, go to ARB_ISSUE.
- While mpu_bsy is high (including post-reset MPU init), req_ready stays 0.

ARB_ISSUE:
- mpu_cs = 1 for exactly this cycle; mpu_* fields hold the latched values from here until return to IDLE.
- Next state ARB_WAIT; clear the watchdog counter.

ARB_WAIT:
- mpu_cs = 0; the watchdog increments each cycle.
- On mpu_rdy:
  - Capture mpu_rdata and mpu_err into resp_rdata/resp_err.
  - Pulse resp_valid[g] for one cycle (the next cycle).
  - If mpu_source_core_id != g, set proto_err; the response is still delivered to g.
  - Go to ARB_RESP.
- If the watchdog reaches TIMEOUT_CYCLES before mpu_rdy:
  - resp_rdata = 0, resp_err = MPU_ACCESS_DENIED, pulse resp_valid[g].
  - Set timeout_err; go to ARB_RESP.

ARB_RESP:
- Hold until mpu_bsy == 0, then go to ARB_IDLE.
- A new grant is possible in the cycle after the MPU drops bsy.

Handshake and ordering:
- Requesters hold their fields stable while valid is high and ready is low.
- Responses have no backpressure.
- Exactly one transaction is outstanding at a time.
- The served core becomes lowest priority next round; no core waits more than NUM_CORES-1 grants.

Latency:
- Accept at T; mpu_cs at T+1; resp_valid in the cycle after mpu_rdy is seen.

Sticky errors:
- timeout_err and proto_err clear only on reset.

Decomposition:
- mpu_common.svh gets arb_state_t (ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP) and DEFAULT_ARB_TIMEOUT.
- Reuses CORE_ID_WIDTH, ADDR_WIDTH, DATA_WIDTH, addr_bits_t, data_bits_t and mpu_error_t from that package.
- One sub-module: rr_arbiter. It is combinational and computes the one-hot grant and index from the request vector and last_grant.

Test Plan:
1. Reset, mpu_bsy held 1 for 20 cycles, req_valid = 4'b0001 -> req_ready stays 0; first accept occurs the cycle after mpu_bsy falls.
2. req_valid = 4'b0011 in the same cycle, MPU model returns rdata 0x100 then 0x200 -> core0 is served first with resp_valid = 4'b0001 and rdata 0x100, then core1 with 4'b0010 and rdata 0x200.
3. All four cores continuously valid for 8 transactions -> grant order 0,1,2,3,0,1,2,3.
4. Core2 access check, MPU returns err = MPU_ACCESS_DENIED with source id 2 -> resp_valid = 4'b0100, resp_err = MPU_ACCESS_DENIED, proto_err stays 0.
5. MPU model never asserts rdy, TIMEOUT_CYCLES = 16 -> resp_valid pulses 16 cycles after the mpu_cs cycle with rdata 0 and err MPU_ACCESS_DENIED; timeout_err = 1 and stays set.
6. MPU echoes source id 3 for a grant to core1 -> resp goes to core1 and proto_err = 1; asserting rst_n = 0 mid-ARB_WAIT returns all outputs to reset values and produces no resp_valid.
